apr_evt_ctl: RTL and testbench
==============================

// Module: apr_evt_ctl
// PURPOSE
//  Parametrised APR event/interrupt controller: NEVT sticky event flags, each with an interrupt enable.
//  Flags and enables are set and cleared from EBUS CONO strobes; flagged-and-enabled events raise a PI request
//  on a programmable level (PIA) with a request/acknowledge handshake. Also provides first-error capture and CONI/diag readback.
//  Sits in the EBOX APR slice. It is the generalised replacement for the fixed eight-event APR1/APR2 logic.
// PARAMETERS
//  NEVT       8          number of event channels (1..16)
//  EBUS_BASE  6          EBUS bit of channel 0; channel i uses EBUS.data[EBUS_BASE+i]
//  EDGE_MASK  'h80       bit i=1: SRC[i] sets flag on falling edge (e.g. SWEEP_BUSY -> sweep done); 0: high level
//  ERR_MASK   'h0B       bit i=1: channel i feeds ANY_EBOX_ERR_FLG and first-error capture
// PORTS
//  clk            in   1      APR clock (CLK.APR)
//  RESET          in   1      synchronous, active-high (CLK.MR_RESET)
//  SRC            in   NEVT   raw event sources (MBOX errors, PWR_WARN, SWEEP_BUSY, ...)
//  SEL_SET        in   1      CONO: set flags whose EBUS bit is 1
//  SEL_CLR        in   1      CONO: clear flags whose EBUS bit is 1
//  SEL_EN         in   1      CONO: set enables whose EBUS bit is 1
//  SEL_DIS        in   1      CONO: clear enables whose EBUS bit is 1
//  LOAD_PIA       in   1      CONO: PIA <= EBUS.data[33:35]
//  EBUS_DATA      in   36     EBUS.data[0:35]
//  PI_ACK         in   1      PI board acknowledge of PI_REQ
//  DIAG_SEL       in   2      readback select: 0 flags,1 enables,2 status,3 counters
//  FLAG           out  NEVT   event flags
//  INT_EN         out  NEVT   interrupt enables
//  APR_INTERRUPT  out  1      |(FLAG & INT_EN)
//  PI_REQ         out  1      interrupt request to PI
//  PIA            out  3      programmed PI level
//  ANY_EBOX_ERR_FLG out 1     registered |(next-FLAG & ERR_MASK)
//  FIRST_ERR_VLD  out  1      first-error latch valid
//  FIRST_ERR_IDX  out  4      index of first error channel
//  CONI_DATA      out  36     readback word, right-justified at EBUS_BASE
// BEHAVIOUR
//  Reset: FLAG, INT_EN, PIA, PI_REQ, ANY_EBOX_ERR_FLG, FIRST_ERR_VLD/IDX = 0; pi state IDLE; edge history <= SRC.
//  Flag next = hit | SEL_SET&b | FLAG&~(SEL_CLR&b); hit = level SRC or detected falling edge; one-cycle latency.
//  Simultaneous hit and SEL_CLR on the same channel: the hit wins (flag stays 1). SET and CLR together: set wins.
//  Enable next = SEL_EN&b | INT_EN&~(SEL_DIS&b); EN and DIS together: EN wins.
//  APR_INTERRUPT is combinational from the registers, so it follows a source by 1 clk.
//  PI FSM (registered): IDLE->REQ when APR_INTERRUPT & PIA!=0; REQ->ACKED on PI_ACK;
//   REQ->IDLE if APR_INTERRUPT drops first; ACKED->IDLE when APR_INTERRUPT=0; PI_REQ = (state==REQ).
//   A PIA reload to 0 while in REQ returns the FSM to IDLE next clk.
//  First error: when VLD=0 and any ERR_MASK flag rises, latch the lowest such index, VLD=1. Further errors are ignored.
//   VLD clears when the latched channel's flag is cleared by CONO.
//  CONI_DATA (comb): sel0 flags, sel1 enables, sel2 {APR_INTERRUPT@32, PIA@33:35, VLD@EBUS_BASE-1, IDX@EBUS_BASE-5..}.
//   Bits not covered by a field read 0.
//  RESET mid-handshake aborts the handshake: PI_REQ drops the next clk.
// CONFIGURATION
//  APR_EVT_COUNT_EN defined: per-channel 8-bit saturating occurrence counters, incremented on each hit.
//   A counter sticks at 255, clears on RESET or on SEL_CLR of its channel.
//   DIAG_SEL=3 reads counter EBUS_DATA[32:35] (index) at bits 28:35.
//  APR_EVT_COUNT_EN undefined: no counters; DIAG_SEL=3 reads all zeros.
// STRUCTURE
//  Package apr_pkg: pi_state_t {IDLE,REQ,ACKED}, DIAG_SEL encodings, PIA field constants (33:35).
//  Sub-module apr_evt_chan: one channel (flag, enable, edge history, optional counter); instantiated NEVT times by generate.
//  Top level: PI FSM, first-error priority encoder, readback mux.
// TESTING
//  1 SRC[0] high for 1 clk, INT_EN=0 -> FLAG[0]=1 next clk, APR_INTERRUPT=0, PI_REQ=0.
//  2 SEL_EN with bit 6, LOAD_PIA=5, pulse SRC[0] -> PI_REQ=1 two clks later, PIA=5;
//    PI_ACK -> ACKED, PI_REQ=0; SEL_CLR bit 6 -> IDLE.
//  3 SRC[7] held 1 then dropped to 0 (edge channel) -> FLAG[7]=1 only after the fall; held high sets nothing.
//  4 SRC[0] and SRC[3] rise in the same clk -> FIRST_ERR_IDX=0, VLD=1; later SRC[1] -> IDX stays 0.
//  5 SEL_CLR bit 6 in the same clk SRC[0]=1 -> FLAG[0] stays 1; PIA set to 0 during REQ -> PI_REQ=0 next clk.
//  6 APR_EVT_COUNT_EN: 300 hits on channel 2 -> DIAG_SEL=3, index 2 reads 255; RESET -> 0.

Source files
------------

// File: rtl/apr_pkg.sv
// Shared constants for the APR event controller: PI handshake states,
// readback selector codes and EBUS field positions (PDP-10 bit order, 0 = MSB).
package apr_pkg;

  typedef logic [1:0] pi_state_t;

  localparam pi_state_t ST_IDLE  = 2'd0;
  localparam pi_state_t ST_REQ   = 2'd1;
  localparam pi_state_t ST_ACKED = 2'd2;

  localparam logic [1:0] DIAG_FLAGS    = 2'd0;
  localparam logic [1:0] DIAG_ENABLES  = 2'd1;
  localparam logic [1:0] DIAG_STATUS   = 2'd2;
  localparam logic [1:0] DIAG_COUNTERS = 2'd3;

  localparam int PIA_MSB       = 33;
  localparam int PIA_LSB       = 35;
  localparam int APR_INT_BIT   = 32;
  localparam int CNT_SEL_MSB   = 32;
  localparam int CNT_SEL_LSB   = 35;
  localparam int CNT_FIELD_MSB = 28;
  localparam int CNT_FIELD_LSB = 35;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/apr_evt_chan.sv
// One APR event channel: sticky flag, interrupt enable, source edge history and,
// with APR_EVT_COUNT_EN defined, an 8-bit saturating hit counter.
module apr_evt_chan
  import apr_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic bit_i,
  input  logic selSet_i,
  input  logic selClr_i,
  input  logic selEn_i,
  input  logic selDis_i,
  output logic flag_o,
  output logic flagNext_o,
  output logic en_o
`ifdef APR_EVT_COUNT_EN
  ,
  output logic [7:0] cnt_o
`endif
);

  logic srcPrev_q;
  logic flag_q, flag_d;
  logic en_q, en_d;
  logic hit, clr;

  // Edge channels fire on a falling source, e.g. SWEEP_BUSY going idle.
  assign hit = EDGE ? (srcPrev_q & ~src_i) : src_i;
  assign clr = selClr_i & bit_i;

  assign flag_d = hit | (selSet_i & bit_i) | (flag_q & ~clr);
  assign en_d   = (selEn_i & bit_i) | (en_q & ~(selDis_i & bit_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_q    <= 1'b0;
      en_q      <= 1'b0;
      srcPrev_q <= src_i;
    end else begin
      flag_q    <= flag_d;
      en_q      <= en_d;
      srcPrev_q <= src_i;
    end
  end

  assign flag_o     = flag_q;
  assign flagNext_o = flag_d;
  assign en_o       = en_q;

`ifdef APR_EVT_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // A clear restarts counting, so a hit in the same cycle counts as the first.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {7'b0, hit};
    end else if (hit && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/apr_evt_ctl.sv
// APR event/interrupt controller top: per-channel flags, PI request handshake,
// first-error capture and CONI readback. Optional counters: APR_EVT_COUNT_EN.
module apr_evt_ctl
  import apr_pkg::*;
#(
  parameter int          NEVT      = 8,
  parameter int          EBUS_BASE = 6,
  parameter logic [15:0] EDGE_MASK = 16'h0080,
  parameter logic [15:0] ERR_MASK  = 16'h000B
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic [NEVT-1:0] SRC,
  input  logic            SEL_SET,
  input  logic            SEL_CLR,
  input  logic            SEL_EN,
  input  logic            SEL_DIS,
  input  logic            LOAD_PIA,
  input  logic [0:35]     EBUS_DATA,
  input  logic            PI_ACK,
  input  logic [1:0]      DIAG_SEL,
  output logic [NEVT-1:0] FLAG,
  output logic [NEVT-1:0] INT_EN,
  output logic            APR_INTERRUPT,
  output logic            PI_REQ,
  output logic [2:0]      PIA,
  output logic            ANY_EBOX_ERR_FLG,
  output logic            FIRST_ERR_VLD,
  output logic [3:0]      FIRST_ERR_IDX,
  output logic [0:35]     CONI_DATA
);

  localparam logic [NEVT-1:0] ERRM = ERR_MASK[NEVT-1:0];

  logic [NEVT-1:0] chanBits, flag_q, flag_d, en_q, clrStrobe, errRise;
  logic [2:0]      pia_q, pia_d;
  pi_state_t       piState_q, piState_d;
  logic            anyErr_q, vld_q, vld_d;
  logic [3:0]      idx_q, idx_d, riseIdx;
  logic            aprInt;
  logic            unusedEbus;

`ifdef APR_EVT_COUNT_EN
  logic [7:0] cnt [NEVT];
  logic [3:0] cntSel;
`endif

  for (genvar i = 0; i < NEVT; i++) begin : g_chan
    assign chanBits[i] = EBUS_DATA[EBUS_BASE+i];
    apr_evt_chan #(.EDGE(EDGE_MASK[i])) u_chan (
      .clk_i      (clk),
      .rst_i      (RESET),
      .src_i      (SRC[i]),
      .bit_i      (chanBits[i]),
      .selSet_i   (SEL_SET),
      .selClr_i   (SEL_CLR),
      .selEn_i    (SEL_EN),
      .selDis_i   (SEL_DIS),
      .flag_o     (flag_q[i]),
      .flagNext_o (flag_d[i]),
      .en_o       (en_q[i])
`ifdef APR_EVT_COUNT_EN
      ,
      .cnt_o      (cnt[i])
`endif
    );
  end

  assign unusedEbus = ^EBUS_DATA;
  assign aprInt     = |(flag_q & en_q);
  assign clrStrobe  = {NEVT{SEL_CLR}} & chanBits;
  assign errRise    = flag_d & ~flag_q & ERRM;
  assign pia_d      = LOAD_PIA ? EBUS_DATA[PIA_MSB:PIA_LSB] : pia_q;

  always_comb begin
    riseIdx = 4'd0;
    for (int i = NEVT - 1; i >= 0; i--) begin
      if (errRise[i]) riseIdx = 4'(i);
    end
  end

  // The latch releases only if the CONO clear actually drops the flag (a same-cycle hit keeps it).
  always_comb begin
    vld_d = vld_q;
    idx_d = idx_q;
    if (!vld_q) begin
      if (|errRise) begin
        vld_d = 1'b1;
        idx_d = riseIdx;
      end
    end else begin
      for (int i = 0; i < NEVT; i++) begin
        if (idx_q == 4'(i) && clrStrobe[i] && !flag_d[i]) begin
          vld_d = 1'b0;
          idx_d = 4'd0;
        end
      end
    end
  end

  // Looking at the next PIA lets a reload to level 0 withdraw the request on the same edge.
  always_comb begin
    piState_d = piState_q;
    case (piState_q)
      ST_IDLE:  if (aprInt && pia_q != 3'd0) piState_d = ST_REQ;
      ST_REQ: begin
        if (!aprInt || pia_d == 3'd0) piState_d = ST_IDLE;
        else if (PI_ACK)              piState_d = ST_ACKED;
      end
      ST_ACKED: if (!aprInt) piState_d = ST_IDLE;
      default:  piState_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      pia_q     <= 3'd0;
      piState_q <= ST_IDLE;
      anyErr_q  <= 1'b0;
      vld_q     <= 1'b0;
      idx_q     <= 4'd0;
    end else begin
      pia_q     <= pia_d;
      piState_q <= piState_d;
      anyErr_q  <= |(flag_d & ERRM);
      vld_q     <= vld_d;
      idx_q     <= idx_d;
    end
  end

`ifdef APR_EVT_COUNT_EN
  assign cntSel = EBUS_DATA[CNT_SEL_MSB:CNT_SEL_LSB];
`endif

  always_comb begin
    CONI_DATA = '0;
    case (DIAG_SEL)
      DIAG_FLAGS: begin
        for (int i = 0; i < NEVT; i++) CONI_DATA[EBUS_BASE+i] = flag_q[i];
      end
      DIAG_ENABLES: begin
        for (int i = 0; i < NEVT; i++) CONI_DATA[EBUS_BASE+i] = en_q[i];
      end
      DIAG_STATUS: begin
        CONI_DATA[APR_INT_BIT]         = aprInt;
        CONI_DATA[PIA_MSB:PIA_LSB]     = pia_q;
        CONI_DATA[EBUS_BASE-1]         = vld_q;
        CONI_DATA[EBUS_BASE-5 +: 4]    = idx_q;
      end
      default: begin
`ifdef APR_EVT_COUNT_EN
        for (int i = 0; i < NEVT; i++) begin
          if (cntSel == 4'(i)) CONI_DATA[CNT_FIELD_MSB:CNT_FIELD_LSB] = cnt[i];
        end
`else
        CONI_DATA = '0;
`endif
      end
    endcase
  end

  assign FLAG             = flag_q;
  assign INT_EN           = en_q;
  assign APR_INTERRUPT    = aprInt;
  assign PI_REQ           = (piState_q == ST_REQ);
  assign PIA              = pia_q;
  assign ANY_EBOX_ERR_FLG = anyErr_q;
  assign FIRST_ERR_VLD    = vld_q;
  assign FIRST_ERR_IDX    = idx_q;

endmodule

// File: tb/tb_apr_evt_ctl.sv
// Directed, table-driven bench for apr_evt_ctl (default parameters), plus
// hand-written sequences for reset mid-handshake and the APR_EVT_COUNT_EN counters.
module tb_apr_evt_ctl;

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  SRC;
  logic        SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA;
  logic [0:35] EBUS_DATA;
  logic        PI_ACK;
  logic [1:0]  DIAG_SEL;
  logic [7:0]  FLAG, INT_EN;
  logic        APR_INTERRUPT, PI_REQ;
  logic [2:0]  PIA;
  logic        ANY_EBOX_ERR_FLG, FIRST_ERR_VLD;
  logic [3:0]  FIRST_ERR_IDX;
  logic [0:35] CONI_DATA;

  int vectors     = 0;
  int miscompares = 0;
  bit vecBad;

  always #5 clk = ~clk;

  apr_evt_ctl dut (
    .clk              (clk),
    .RESET            (RESET),
    .SRC              (SRC),
    .SEL_SET          (SEL_SET),
    .SEL_CLR          (SEL_CLR),
    .SEL_EN           (SEL_EN),
    .SEL_DIS          (SEL_DIS),
    .LOAD_PIA         (LOAD_PIA),
    .EBUS_DATA        (EBUS_DATA),
    .PI_ACK           (PI_ACK),
    .DIAG_SEL         (DIAG_SEL),
    .FLAG             (FLAG),
    .INT_EN           (INT_EN),
    .APR_INTERRUPT    (APR_INTERRUPT),
    .PI_REQ           (PI_REQ),
    .PIA              (PIA),
    .ANY_EBOX_ERR_FLG (ANY_EBOX_ERR_FLG),
    .FIRST_ERR_VLD    (FIRST_ERR_VLD),
    .FIRST_ERR_IDX    (FIRST_ERR_IDX),
    .CONI_DATA        (CONI_DATA)
  );

  // One clock of stimulus and the outputs expected just after that edge.
  // cono packs {SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA}.
  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] src;
    logic [4:0] cono;
    logic [7:0] chan;
    logic [2:0] piaIn;
    logic       ack;
    logic [1:0] diag;
    logic [7:0] eFlag;
    logic [7:0] eEn;
    logic       eInt;
    logic       eReq;
    logic [2:0] ePia;
    logic       eErr;
    logic       eVld;
    logic [3:0] eIdx;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic rst, input logic [7:0] src,
                        input logic [4:0] cono, input logic [7:0] chan, input logic [2:0] piaIn,
                        input logic ack, input logic [1:0] diag, input logic [7:0] eFlag,
                        input logic [7:0] eEn, input logic [1:0] eIntReq, input logic [2:0] ePia,
                        input logic [1:0] eErrVld, input logic [3:0] eIdx);
    vec_t v;
    v.name = n; v.rst = rst; v.src = src; v.cono = cono; v.chan = chan; v.piaIn = piaIn;
    v.ack = ack; v.diag = diag; v.eFlag = eFlag; v.eEn = eEn;
    v.eInt = eIntReq[1]; v.eReq = eIntReq[0]; v.ePia = ePia;
    v.eErr = eErrVld[1]; v.eVld = eErrVld[0]; v.eIdx = eIdx;
    vecs.push_back(v);
  endtask

  function automatic logic [0:35] ebusWord(input logic [7:0] chan, input logic [2:0] piaIn);
    logic [0:35] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[6+i] = chan[i];
    e[33:35] = piaIn;
    return e;
  endfunction

  // Readback layout: channels at bits 6..13, status INT@32, PIA@33:35, VLD@5, IDX@1:4.
  function automatic logic [0:35] coniExp(input vec_t v);
    logic [0:35] c;
    c = '0;
    case (v.diag)
      2'd0: for (int i = 0; i < 8; i++) c[6+i] = v.eFlag[i];
      2'd1: for (int i = 0; i < 8; i++) c[6+i] = v.eEn[i];
      2'd2: begin
        c[32]    = v.eInt;
        c[33:35] = v.ePia;
        c[5]     = v.eVld;
        c[1:4]   = v.eIdx;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic cmp(input string vn, input string field, input logic [35:0] act,
                     input logic [35:0] exp);
    if (act !== exp) begin
      $display("[TB] FAIL %s.%s got %0h want %0h", vn, field, act, exp);
      vecBad = 1'b1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    RESET     = v.rst;
    SRC       = v.src;
    {SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA} = v.cono;
    EBUS_DATA = ebusWord(v.chan, v.piaIn);
    PI_ACK    = v.ack;
    DIAG_SEL  = v.diag;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    vecBad = 1'b0;
    cmp(v.name, "FLAG",   36'(FLAG),             36'(v.eFlag));
    cmp(v.name, "INT_EN", 36'(INT_EN),           36'(v.eEn));
    cmp(v.name, "APRINT", 36'(APR_INTERRUPT),    36'(v.eInt));
    cmp(v.name, "PI_REQ", 36'(PI_REQ),           36'(v.eReq));
    cmp(v.name, "PIA",    36'(PIA),              36'(v.ePia));
    cmp(v.name, "ANYERR", 36'(ANY_EBOX_ERR_FLG), 36'(v.eErr));
    cmp(v.name, "VLD",    36'(FIRST_ERR_VLD),    36'(v.eVld));
    cmp(v.name, "IDX",    36'(FIRST_ERR_IDX),    36'(v.eIdx));
    cmp(v.name, "CONI",   36'(CONI_DATA),        36'(coniExp(v)));
    vectors++;
    if (vecBad) miscompares++;
  endtask

  task automatic checkSeq(input string n, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      $display("[TB] FAIL %s got %0h want %0h", n, act, exp);
      miscompares++;
    end
  endtask

  task automatic idleInputs();
    RESET = 1'b0; SRC = 8'h00;
    {SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA} = 5'b0;
    EBUS_DATA = '0; PI_ACK = 1'b0; DIAG_SEL = 2'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expCnt255, expCnt10;
    bit seen;
    //     name           rst   src    cono      chan   pia   ack   dg    flag   en     int/req pia  err/vld idx
    addVec("reset",       1'b1, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("src0_pulse",  1'b0, 8'h01, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h00, 2'b00, 3'd0, 2'b11, 4'd0);
    addVec("src0_sticky", 1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h00, 2'b00, 3'd0, 2'b11, 4'd0);
    addVec("clr_ch0",     1'b0, 8'h00, 5'b01000, 8'h01, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("en_pia5",     1'b0, 8'h00, 5'b00101, 8'h01, 3'd5, 1'b0, 2'd0, 8'h00, 8'h01, 2'b00, 3'd5, 2'b00, 4'd0);
    addVec("src0_int",    1'b0, 8'h01, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd5, 2'b11, 4'd0);
    addVec("req_up",      1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b11, 3'd5, 2'b11, 4'd0);
    addVec("ack",         1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b1, 2'd0, 8'h01, 8'h01, 2'b10, 3'd5, 2'b11, 4'd0);
    addVec("acked_hold",  1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd5, 2'b11, 4'd0);
    addVec("acked_clr",   1'b0, 8'h00, 5'b01000, 8'h01, 3'd0, 1'b0, 2'd0, 8'h00, 8'h01, 2'b00, 3'd5, 2'b00, 4'd0);
    addVec("back_idle",   1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 8'h01, 2'b00, 3'd5, 2'b00, 4'd0);
    addVec("src0_again",  1'b0, 8'h01, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd5, 2'b11, 4'd0);
    addVec("req_again",   1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b11, 3'd5, 2'b11, 4'd0);
    addVec("pia0_in_req", 1'b0, 8'h00, 5'b00001, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd0, 2'b11, 4'd0);
    addVec("pia0_hold",   1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd0, 2'b11, 4'd0);
    addVec("pia5_reload", 1'b0, 8'h00, 5'b00001, 8'h00, 3'd5, 1'b0, 2'd0, 8'h01, 8'h01, 2'b10, 3'd5, 2'b11, 4'd0);
    addVec("req_pia5",    1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h01, 2'b11, 3'd5, 2'b11, 4'd0);
    addVec("dis_in_req",  1'b0, 8'h00, 5'b00010, 8'h01, 3'd0, 1'b0, 2'd0, 8'h01, 8'h00, 2'b01, 3'd5, 2'b11, 4'd0);
    addVec("req_drops",   1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h01, 8'h00, 2'b00, 3'd5, 2'b11, 4'd0);
    addVec("hit_vs_clr",  1'b0, 8'h01, 5'b01000, 8'h01, 3'd0, 1'b0, 2'd0, 8'h01, 8'h00, 2'b00, 3'd5, 2'b11, 4'd0);
    addVec("set_and_clr", 1'b0, 8'h00, 5'b11000, 8'h04, 3'd0, 1'b0, 2'd0, 8'h05, 8'h00, 2'b00, 3'd5, 2'b11, 4'd0);
    addVec("en_and_dis",  1'b0, 8'h00, 5'b00110, 8'h02, 3'd0, 1'b0, 2'd2, 8'h05, 8'h02, 2'b00, 3'd5, 2'b11, 4'd0);
    addVec("diag_en",     1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd1, 8'h05, 8'h02, 2'b00, 3'd5, 2'b11, 4'd0);
    addVec("reset2",      1'b1, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("src7_rise",   1'b0, 8'h80, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("src7_hold",   1'b0, 8'h80, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("src7_fall",   1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h80, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("src7_sticky", 1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h80, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("err0_and_3",  1'b0, 8'h09, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h89, 8'h00, 2'b00, 3'd0, 2'b11, 4'd0);
    addVec("err1_later",  1'b0, 8'h02, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h8B, 8'h00, 2'b00, 3'd0, 2'b11, 4'd0);
    addVec("reset3_d3",   1'b1, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd3, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("err1_and_3",  1'b0, 8'h0A, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd0, 8'h0A, 8'h00, 2'b00, 3'd0, 2'b11, 4'd1);
    addVec("status_idx1", 1'b0, 8'h00, 5'b00000, 8'h00, 3'd0, 1'b0, 2'd2, 8'h0A, 8'h00, 2'b00, 3'd0, 2'b11, 4'd1);
    addVec("clr_other",   1'b0, 8'h00, 5'b01000, 8'h08, 3'd0, 1'b0, 2'd0, 8'h02, 8'h00, 2'b00, 3'd0, 2'b11, 4'd1);
    addVec("clr_latched", 1'b0, 8'h00, 5'b01000, 8'h02, 3'd0, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);
    addVec("set_only",    1'b0, 8'h00, 5'b10000, 8'h10, 3'd0, 1'b0, 2'd0, 8'h10, 8'h00, 2'b00, 3'd0, 2'b00, 4'd0);

    idleInputs();
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Reset in the middle of a pending request must drop PI_REQ on the next clock.
    @(negedge clk); idleInputs(); RESET = 1'b1;
    @(negedge clk); RESET = 1'b0;
    SEL_EN = 1'b1; LOAD_PIA = 1'b1; EBUS_DATA = ebusWord(8'h01, 3'd3);
    @(negedge clk); idleInputs(); SRC = 8'h01;
    @(negedge clk); SRC = 8'h00;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      seen = PI_REQ;
    end
    checkSeq("mid_req_seen", 36'(seen), 36'd1);
    @(negedge clk); RESET = 1'b1;
    @(posedge clk); #1;
    checkSeq("reset_abort_req", 36'(PI_REQ), 36'd0);
    checkSeq("reset_abort_pia", 36'(PIA), 36'd0);
    @(negedge clk); idleInputs();

    // Counter sequence: level hits on channel 2, read back through DIAG_SEL=3.
`ifdef APR_EVT_COUNT_EN
    expCnt10 = 10; expCnt255 = 255;
`else
    expCnt10 = 0;  expCnt255 = 0;
`endif
    SRC = 8'h04;
    repeat (10) @(posedge clk);
    @(negedge clk); SRC = 8'h00; DIAG_SEL = 2'd3; EBUS_DATA = '0; EBUS_DATA[32:35] = 4'd2;
    #1;
    checkSeq("cnt2_after10", 36'(CONI_DATA[28:35]), 36'(expCnt10));
    checkSeq("cnt_rest_zero", 36'(CONI_DATA[0:27]), 36'd0);
    SRC = 8'h04;
    repeat (290) @(posedge clk);
    @(negedge clk); SRC = 8'h00;
    #1;
    checkSeq("cnt2_saturate", 36'(CONI_DATA[28:35]), 36'(expCnt255));
    EBUS_DATA[32:35] = 4'd3;
    #1;
    checkSeq("cnt3_idle", 36'(CONI_DATA), 36'd0);
    EBUS_DATA[32:35] = 4'd2;
    RESET = 1'b1;
    @(posedge clk); #1;
    checkSeq("cnt2_reset", 36'(CONI_DATA), 36'd0);
    @(negedge clk); idleInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
